// File: rtl/aes_dec_pkg.sv
// AES inverse-cipher shared types, tables and GF(2^8) helpers.
// Used by the iterative decrypt engine and its round datapath.
package aes_dec_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  function automatic int nr_of(input int key_bits);
    return key_bits / 32 + 6;
  endfunction

  // Byte 0 of the table sits in the top 8 bits.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] b);
    return xt(xt(xt(b))) ^ b;
  endfunction

  function automatic logic [7:0] mul11(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(b) ^ b;
  endfunction

  function automatic logic [7:0] mul13(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
  endfunction

  function automatic logic [7:0] mul14(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
  endfunction

endpackage

// File: rtl/aes_dec_round.sv
// One AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the final round.
module aes_dec_round
  import aes_dec_pkg::*;
(
  input  logic [127:0] data,
  input  logic [127:0] rkey,
  input  logic         last,
  output logic [127:0] result
);

  logic [7:0] sb [16];
  logic [7:0] ak [16];
  logic [7:0] mc [16];

  // Byte i is row i%4, column i/4; row r rotates right by r.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      sb[i] = inv_sbox(
        data[127 - 8 * (4 * (((i / 4) - (i % 4)) & 3) + (i % 4)) -: 8]);
      ak[i] = sb[i] ^ rkey[127 - 8 * i -: 8];
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        mc[4 * c + r] = mul14(ak[4 * c + r])
                      ^ mul11(ak[4 * c + ((r + 1) % 4)])
                      ^ mul13(ak[4 * c + ((r + 2) % 4)])
                      ^ mul9(ak[4 * c + ((r + 3) % 4)]);
      end
    end
    result = '0;
    for (int i = 0; i < 16; i++) begin
      result[127 - 8 * i -: 8] = last ? ak[i] : mc[i];
    end
  end

endmodule

// File: rtl/aes_dec_iter.sv
// Iterative AES decryptor: one round per cycle, keys fetched by index
// from an external store, optional CBC chaining on the output.
module aes_dec_iter
  import aes_dec_pkg::*;
#(
  parameter int KEY_BITS = 128,
  parameter bit CBC_EN   = 1'b0
) (
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic         i_Din_Valid,
  output logic         o_Din_Ready,
  input  logic [127:0] i_Din,
  input  logic         i_Iv_Load,
  input  logic [127:0] i_Iv,
  output logic [3:0]   o_Key_Addr,
  input  logic [127:0] i_Round_Key,
  output logic [127:0] o_Dout,
  output logic         o_Dout_Valid,
  input  logic         i_Dout_Ready,
  output logic         o_Busy
);

  localparam int NR = nr_of(KEY_BITS);
  localparam logic [3:0] NR4 = 4'(NR);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
    $error("aes_dec_iter: KEY_BITS must be 128, 192 or 256");
  end

  state_e       st, st_n;
  logic [127:0] blk, rnd, dout_raw;
  logic [3:0]   cnt;
  logic         accept;

  aes_dec_round u_round (
    .data   (blk),
    .rkey   (i_Round_Key),
    .last   (cnt == 4'd0),
    .result (rnd)
  );

  always_comb begin
    st_n         = st;
    o_Din_Ready  = 1'b0;
    o_Busy       = 1'b1;
    o_Dout_Valid = 1'b0;
    o_Key_Addr   = NR4;
    unique case (st)
      S_IDLE: begin
        o_Din_Ready = 1'b1;
        o_Busy      = 1'b0;
        if (i_Din_Valid) st_n = S_RUN;
      end
      S_RUN: begin
        o_Key_Addr = cnt;
        if (cnt == 4'd0) st_n = S_DONE;
      end
      S_DONE: begin
        o_Dout_Valid = 1'b1;
        if (i_Dout_Ready) st_n = S_IDLE;
      end
      default: st_n = S_IDLE;
    endcase
  end

  assign accept = (st == S_IDLE) && i_Din_Valid;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      st  <= S_IDLE;
      blk <= '0;
      cnt <= '0;
    end else begin
      st <= st_n;
      if (accept) begin
        blk <= i_Din ^ i_Round_Key;
        cnt <= NR4 - 4'd1;
      end else if (st == S_RUN) begin
        blk <= rnd;
        if (cnt != 4'd0) cnt <= cnt - 4'd1;
      end
    end
  end

  if (CBC_EN) begin : g_cbc
    logic [127:0] ct_reg, chain;

    // A load coinciding with accept lands before this block's output.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
        ct_reg <= '0;
        chain  <= '0;
      end else begin
        if (accept) ct_reg <= i_Din;
        if (st == S_IDLE && i_Iv_Load) chain <= i_Iv;
        else if (st == S_DONE && i_Dout_Ready) chain <= ct_reg;
      end
    end

    assign dout_raw = blk ^ chain;
  end else begin : g_ecb
    logic unused_iv;
    assign unused_iv = ^{i_Iv_Load, i_Iv};
    assign dout_raw  = blk;
  end

  assign o_Dout = o_Dout_Valid ? dout_raw : '0;

endmodule

// File: tb/tb_aes_dec_iter.sv
// Scoreboard bench for aes_dec_iter: AES-128/192/256 and CBC-128
// instances, with a key store built from the bench's own key schedule.
module tb_aes_dec_iter;

  localparam int NI = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         din_valid  [NI];
  logic         din_ready  [NI];
  logic [127:0] din        [NI];
  logic         iv_load    [NI];
  logic [127:0] iv         [NI];
  logic [3:0]   kaddr      [NI];
  logic [127:0] rkey       [NI];
  logic [127:0] dout       [NI];
  logic         dout_valid [NI];
  logic         dout_ready [NI];
  logic         busy       [NI];
  logic [127:0] rks        [NI][16];
  int           nr_i       [NI] = '{10, 12, 14, 10};

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int KB = (g == 1) ? 192 : (g == 2) ? 256 : 128;
    localparam bit CB = (g == 3);
    aes_dec_iter #(.KEY_BITS(KB), .CBC_EN(CB)) u_dut (
      .i_Clk        (clk),
      .i_Rst        (rst),
      .i_Din_Valid  (din_valid[g]),
      .o_Din_Ready  (din_ready[g]),
      .i_Din        (din[g]),
      .i_Iv_Load    (iv_load[g]),
      .i_Iv         (iv[g]),
      .o_Key_Addr   (kaddr[g]),
      .i_Round_Key  (rkey[g]),
      .o_Dout       (dout[g]),
      .o_Dout_Valid (dout_valid[g]),
      .i_Dout_Ready (dout_ready[g]),
      .o_Busy       (busy[g])
    );
    assign rkey[g] = rks[g][kaddr[g]];
  end

  typedef struct {
    int           id;
    logic [127:0] pt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  logic [7:0] fsb [256];

  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] CKEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CIV   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CCT1  = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] CPT1  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CCT2  = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] CPT2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

  task automatic chk(input string nm, input logic [127:0] got,
                     input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {fsb[t[31:24]], fsb[t[23:16]], fsb[t[15:8]], fsb[t[7:0]]};
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      fsb[x] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand(input int g, input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i - 1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i - nk] ^ t;
    end
    for (int r = 0; r < 16; r++) rks[g][r] = '0;
    for (int r = 0; r <= nr; r++)
      rks[g][r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  // Starts at #1 after a rising edge with the DUT idle; returns at the
  // falling edge where o_Dout_Valid is first seen.
  task automatic run_block(input int g, input logic [127:0] ct,
                           input logic [127:0] pt, input bit ld,
                           input logic [127:0] ivv, input bit noise);
    exp_t e;
    int   addrs[$];
    int   edges;
    bit   seen, ok;
    int   nr;
    nr = nr_i[g];
    e.id = g;
    e.pt = pt;
    sb.push_back(e);
    din[g] = ct;
    din_valid[g] = 1'b1;
    if (ld) begin
      iv[g] = ivv;
      iv_load[g] = 1'b1;
    end
    @(negedge clk);
    addrs.push_back(int'(kaddr[g]));
    @(posedge clk);
    edges = 1;
    #1;
    din_valid[g] = 1'b0;
    iv_load[g] = 1'b0;
    seen = 1'b0;
    while (!seen && edges < 40) begin
      @(negedge clk);
      if (dout_valid[g]) begin
        seen = 1'b1;
      end else begin
        addrs.push_back(int'(kaddr[g]));
        @(posedge clk);
        edges++;
        #1;
        if (noise) begin
          iv_load[g] = 1'b1;
          iv[g] = ~ivv;
        end
      end
    end
    iv_load[g] = 1'b0;
    chk($sformatf("latency_dut%0d", g), 128'(edges), 128'(nr + 1));
    ok = (addrs.size() == nr + 1);
    for (int i = 0; i < addrs.size(); i++)
      if (addrs[i] != nr - i) ok = 1'b0;
    chk($sformatf("keyaddr_seq_dut%0d", g), 128'(ok), 128'(1));
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (!rst && dout_valid[g] && dout_ready[g]) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_dout_dut%0d got %h expected no output",
                   g, dout[g]);
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.id != g || dout[g] !== mon_e.pt) begin
            n_err++;
            $display("FAIL dout_dut%0d got %h expected %h from dut%0d",
                     g, dout[g], mon_e.pt, mon_e.id);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] seqkey;
    logic [127:0] hold;
    rst = 1'b0;
    for (int g = 0; g < NI; g++) begin
      din_valid[g] = 1'b0;
      din[g] = '0;
      iv_load[g] = 1'b0;
      iv[g] = '0;
      dout_ready[g] = 1'b1;
    end
    build_sbox();
    for (int i = 0; i < 32; i++) seqkey[255 - 8 * i -: 8] = 8'(i);
    expand(0, seqkey, 4);
    expand(1, seqkey, 6);
    expand(2, seqkey, 8);
    expand(3, {CKEY, 128'h0}, 4);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("rst_busy_dut%0d", g), 128'(busy[g]), 128'(0));
      chk($sformatf("rst_din_ready_dut%0d", g), 128'(din_ready[g]), 128'(1));
      chk($sformatf("rst_dout_valid_dut%0d", g), 128'(dout_valid[g]), 128'(0));
      chk($sformatf("rst_key_addr_dut%0d", g), 128'(kaddr[g]), 128'(nr_i[g]));
      chk($sformatf("rst_dout_dut%0d", g), dout[g], 128'h0);
    end
    @(posedge clk);
    #1 rst = 1'b0;

    run_block(0, CT128, PT, 1'b0, '0, 1'b0);
    @(posedge clk); #1;
    run_block(1, CT192, PT, 1'b0, '0, 1'b0);
    @(posedge clk); #1;
    run_block(2, CT256, PT, 1'b0, '0, 1'b0);
    @(posedge clk); #1;

    iv[3] = '1;
    iv_load[3] = 1'b1;
    @(posedge clk); #1;
    iv_load[3] = 1'b0;
    run_block(3, CCT1, CPT1, 1'b1, CIV, 1'b0);
    @(posedge clk); #1;
    run_block(3, CCT2, CPT2, 1'b0, CCT1, 1'b1);
    @(posedge clk); #1;

    din[0] = CT128;
    din_valid[0] = 1'b1;
    @(posedge clk); #1;
    din_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrun_rst_busy", 128'(busy[0]), 128'(0));
    chk("midrun_rst_din_ready", 128'(din_ready[0]), 128'(1));
    chk("midrun_rst_dout_valid", 128'(dout_valid[0]), 128'(0));
    chk("midrun_rst_key_addr", 128'(kaddr[0]), 128'(10));
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    run_block(0, CT128, PT, 1'b0, '0, 1'b0);
    @(posedge clk); #1;

    dout_ready[0] = 1'b0;
    run_block(0, CT128, PT, 1'b0, '0, 1'b0);
    hold = dout[0];
    chk("bp_first_dout", hold, PT);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_stable_%0d", k), dout[0], hold);
      chk($sformatf("bp_valid_%0d", k), 128'(dout_valid[0]), 128'(1));
      chk($sformatf("bp_din_ready_%0d", k), 128'(din_ready[0]), 128'(0));
      @(posedge clk); #1;
      din_valid[0] = (k % 2 == 1);
      din[0] = CT192;
      if (k == 4) dout_ready[0] = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_pulse_ignored_busy", 128'(busy[0]), 128'(0));
    chk("bp_idle_dout_valid", 128'(dout_valid[0]), 128'(0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sb_drained", 128'(sb.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
